// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-legality helper for the load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned F3_W_W = 3;

    localparam logic [F3_W_W-1:0] F3_B  = 3'b000;
    localparam logic [F3_W_W-1:0] F3_H  = 3'b001;
    localparam logic [F3_W_W-1:0] F3_W  = 3'b010;
    localparam logic [F3_W_W-1:0] F3_BU = 3'b100;
    localparam logic [F3_W_W-1:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Returns 1 for an access that must be rejected: illegal funct3 for the direction, or misaligned.
    function automatic logic access_bad(input logic we, input logic [F3_W_W-1:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side and data-memory-side signals of the LSU; slave = LSU, master = pipeline/memory.
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_W   = 5
);

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [F3_W_W-1:0]   req_f3;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [RD_W-1:0]     req_rd;
    logic                flush;

    logic                dm_req;
    logic [BE_W-1:0]     dm_we;
    logic [ADDR_W-1:0]   dm_addr;
    logic [DATA_W-1:0]   dm_wdata;
    logic                dm_gnt;
    logic                dm_rvalid;
    logic [DATA_W-1:0]   dm_rdata;

    logic                wb_valid;
    logic [RD_W-1:0]     wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                st_done;
    logic                misalign;
    logic                busy;

    modport slave (
        input  req_valid, req_we, req_f3, req_addr, req_wdata, req_rd, flush,
        input  dm_gnt, dm_rvalid, dm_rdata,
        output req_ready, dm_req, dm_we, dm_addr, dm_wdata,
        output wb_valid, wb_rd, wb_data, st_done, misalign, busy
    );

    modport master (
        output req_valid, req_we, req_f3, req_addr, req_wdata, req_rd, flush,
        output dm_gnt, dm_rvalid, dm_rdata,
        input  req_ready, dm_req, dm_we, dm_addr, dm_wdata,
        input  wb_valid, wb_rd, wb_data, st_done, misalign, busy
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes/replicated data and load shift + extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [F3_W_W-1:0] f3,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   dm_we_c,
    output logic [DATA_W-1:0] dm_wdata_c,
    output logic [DATA_W-1:0] ldata_c
);

    logic [DATA_W-1:0] sh;

    // Store strobes by size; data is replicated so every lane carries the value.
    always_comb begin
        dm_we_c    = '0;
        dm_wdata_c = '0;
        case (f3[1:0])
            2'b00: begin
                dm_we_c    = BE_W'(4'b0001 << off);
                dm_wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                dm_we_c    = BE_W'(4'b0011 << off);
                dm_wdata_c = {2{wdata[15:0]}};
            end
            default: begin
                dm_we_c    = 4'b1111;
                dm_wdata_c = wdata;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then sign- or zero-extend.
    always_comb begin
        sh      = rdata >> {off, 3'b000};
        ldata_c = sh;
        case (f3)
            F3_B:    ldata_c = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   ldata_c = {24'h000000, sh[7:0]};
            F3_H:    ldata_c = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   ldata_c = {16'h0000, sh[15:0]};
            default: ldata_c = sh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer between the pipeline and a handshaked data memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_W   = 5
)(
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [F3_W_W-1:0]   f3_q, f3_d;
    logic [1:0]          off_q, off_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic                drop_q, drop_d;

    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                dm_req_q, dm_req_d;
    logic [BE_W-1:0]     dm_we_q, dm_we_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                st_done_q, st_done_d;
    logic                misalign_q, misalign_d;

    logic                hs_c;
    logic [F3_W_W-1:0]   al_f3_c;
    logic [1:0]          al_off_c;
    logic [BE_W-1:0]     al_we_c;
    logic [DATA_W-1:0]   al_wdata_c;
    logic [DATA_W-1:0]   al_ldata_c;

    // In IDLE the aligner sees the incoming request; afterwards the captured one.
    always_comb begin
        hs_c     = bus.req_valid & req_ready_q;
        al_f3_c  = (state_q == IDLE) ? bus.req_f3 : f3_q;
        al_off_c = (state_q == IDLE) ? bus.req_addr[1:0] : off_q;
    end

    lsu_align u_align (
        .f3         (al_f3_c),
        .off        (al_off_c),
        .wdata      (bus.req_wdata),
        .rdata      (bus.dm_rdata),
        .dm_we_c    (al_we_c),
        .dm_wdata_c (al_wdata_c),
        .ldata_c    (al_ldata_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        drop_d     = drop_q;
        dm_req_d   = 1'b0;
        dm_we_d    = '0;
        dm_addr_d  = '0;
        dm_wdata_d = '0;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        st_done_d  = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs_c) begin
                    we_d   = bus.req_we;
                    f3_d   = bus.req_f3;
                    off_d  = bus.req_addr[1:0];
                    rd_d   = bus.req_rd;
                    drop_d = 1'b0;
                    if (access_bad(bus.req_we, bus.req_f3, bus.req_addr[1:0])) begin
                        state_d    = ERR;
                        misalign_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        dm_req_d   = 1'b1;
                        dm_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        dm_we_d    = bus.req_we ? al_we_c : '0;
                        dm_wdata_d = bus.req_we ? al_wdata_c : '0;
                    end
                end
            end
            REQ: begin
                dm_req_d   = 1'b1;
                dm_we_d    = dm_we_q;
                dm_addr_d  = dm_addr_q;
                dm_wdata_d = dm_wdata_q;
                if (bus.dm_gnt) begin
                    dm_req_d   = 1'b0;
                    dm_we_d    = '0;
                    dm_addr_d  = '0;
                    dm_wdata_d = '0;
                    if (we_q) begin
                        // A granted store has committed; a simultaneous flush cannot undo it.
                        state_d   = IDLE;
                        st_done_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        drop_d  = drop_q | bus.flush;
                    end
                end else if (bus.flush) begin
                    state_d    = IDLE;
                    dm_req_d   = 1'b0;
                    dm_we_d    = '0;
                    dm_addr_d  = '0;
                    dm_wdata_d = '0;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    drop_d = 1'b1;
                end
                if (bus.dm_rvalid) begin
                    state_d = RESP;
                    if (!(drop_q | bus.flush)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = al_ldata_c;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State, capture and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            drop_q      <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= '0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            st_done_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            drop_q      <= drop_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            st_done_q   <= st_done_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.dm_req    = dm_req_q;
    assign bus.dm_we     = dm_we_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_wdata  = dm_wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.st_done   = st_done_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_lsu_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned RD_W   = 5;

    localparam logic [1:0] K_WB  = 2'd0;
    localparam logic [1:0] K_ST  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    exp_t sb_q[$];

    lsu_if #(.ADDR_W(ADDR_W), .RD_W(RD_W)) bus ();

    lsu_ctrl #(.ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [1:0] kind, input logic [31:0] data, input logic [4:0] rd);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.rd   = rd;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [1:0] kind, input logic [31:0] data, input logic [4:0] rd);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL sb_unexpected: got pulse kind=%0d data=%h expected no pulse (t=%0t)", kind, data, $time);
        end else begin
            e = sb_q.pop_front();
            check("sb_kind", 32'(kind), 32'(e.kind));
            if (e.kind == K_WB) begin
                check("sb_wb_data", data, e.data);
                check("sb_wb_rd", 32'(rd), 32'(e.rd));
            end
        end
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wb_valid) sb_check(K_WB, bus.wb_data, bus.wb_rd);
            if (bus.st_done)  sb_check(K_ST, 32'h0, 5'd0);
            if (bus.misalign) sb_check(K_ERR, 32'h0, 5'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        check("pre_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_f3    = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_rd    = rd;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic [31:0] exp);
        logic [31:0] wa;
        wa = addr & 32'hFFFF_FFFC;
        sb_push(K_WB, exp, rd);
        issue(1'b0, f3, addr, 32'h0, rd);
        check("ld_dm_req", 32'(bus.dm_req), 32'd1);
        check("ld_dm_we", 32'(bus.dm_we), 32'd0);
        check("ld_dm_addr", bus.dm_addr, wa);
        bus.dm_gnt = 1'b1;
        step();
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = rdata;
        step();
        bus.dm_rvalid = 1'b0;
        check("ld_resp_ready", 32'(bus.req_ready), 32'd0);
        step();
        check("ld_wb_one_cycle", 32'(bus.wb_valid), 32'd0);
        check("ld_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic store_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] exp_we, input logic [31:0] exp_wd, input logic flush_at_gnt);
        sb_push(K_ST, 32'h0, 5'd0);
        issue(1'b1, f3, addr, wdata, 5'd0);
        check("st_dm_req", 32'(bus.dm_req), 32'd1);
        check("st_dm_we", 32'(bus.dm_we), 32'(exp_we));
        check("st_dm_wdata", bus.dm_wdata, exp_wd);
        check("st_dm_addr", bus.dm_addr, addr & 32'hFFFF_FFFC);
        bus.dm_gnt = 1'b1;
        bus.flush  = flush_at_gnt;
        step();
        bus.dm_gnt = 1'b0;
        bus.flush  = 1'b0;
        check("st_dm_req_drop", 32'(bus.dm_req), 32'd0);
        step();
        check("st_done_one_cycle", 32'(bus.st_done), 32'd0);
    endtask

    task automatic err_op(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        sb_push(K_ERR, 32'h0, 5'd0);
        issue(we, f3, addr, 32'h1234_5678, 5'd3);
        check("err_no_req", 32'(bus.dm_req), 32'd0);
        check("err_ready_low", 32'(bus.req_ready), 32'd0);
        step();
        check("err_no_req2", 32'(bus.dm_req), 32'd0);
        check("err_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]  we0;
        logic [31:0] ad0;
        logic [31:0] wd0;
        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_f3    = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_rd    = 5'd0;
        bus.flush     = 1'b0;
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = 32'h0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dm_req", 32'(bus.dm_req), 32'd0);
        check("rst_dm_we", 32'(bus.dm_we), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_st_done", 32'(bus.st_done), 32'd0);
        check("rst_misalign", 32'(bus.misalign), 32'd0);

        // Stray read data while idle is ignored
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'hDEAD_BEEF;
        step();
        bus.dm_rvalid = 1'b0;
        check("stray_busy", 32'(bus.busy), 32'd0);

        // Loads: lane shift and extension
        load_op(3'b000, 32'h0000_0103, 32'h8011_2233, 5'd1, 32'hFFFF_FF80);
        load_op(3'b101, 32'h0000_0102, 32'hBEEF_1234, 5'd2, 32'h0000_BEEF);
        load_op(3'b001, 32'h0000_0102, 32'hBEEF_1234, 5'd3, 32'hFFFF_BEEF);
        load_op(3'b100, 32'h0000_0101, 32'h8011_2233, 5'd4, 32'h0000_0022);
        load_op(3'b010, 32'h0000_0104, 32'h1234_5678, 5'd5, 32'h1234_5678);
        load_op(3'b000, 32'h0000_0100, 32'h0000_007F, 5'd31, 32'h0000_007F);

        // Stores: strobes and replicated lanes
        store_op(3'b001, 32'h0000_0202, 32'h1234_A5C3, 4'b1100, 32'hA5C3_A5C3, 1'b0);
        store_op(3'b000, 32'h0000_0201, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A, 1'b0);
        store_op(3'b010, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b0);
        // Flush together with the grant is too late: the store still completes
        store_op(3'b000, 32'h0000_0207, 32'h0000_00E1, 4'b1000, 32'hE1E1_E1E1, 1'b1);

        // Rejected accesses
        err_op(1'b0, 3'b010, 32'h0000_0301);
        err_op(1'b1, 3'b100, 32'h0000_0300);
        err_op(1'b0, 3'b001, 32'h0000_0105);
        err_op(1'b0, 3'b011, 32'h0000_0100);

        // Grant withheld: request held stable, then flushed away
        issue(1'b1, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 5'd0);
        we0 = bus.dm_we;
        ad0 = bus.dm_addr;
        wd0 = bus.dm_wdata;
        check("stall_we", 32'(we0), 32'hF);
        check("stall_addr", ad0, 32'h0000_0400);
        for (int c = 1; c <= 3; c++) begin
            check("stall_req", 32'(bus.dm_req), 32'd1);
            check("stall_we_hold", 32'(bus.dm_we), 32'(we0));
            check("stall_addr_hold", bus.dm_addr, ad0);
            check("stall_wdata_hold", bus.dm_wdata, wd0);
            if (c == 3) bus.flush = 1'b1;
            step();
        end
        bus.flush = 1'b0;
        check("flush_req_gone", 32'(bus.dm_req), 32'd0);
        check("flush_idle", 32'(bus.busy), 32'd0);
        step();
        step();

        // Flush in WAIT: the later response is dropped
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd7);
        bus.dm_gnt = 1'b1;
        step();
        bus.dm_gnt = 1'b0;
        bus.flush  = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        step();
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h5555_AAAA;
        step();
        bus.dm_rvalid = 1'b0;
        check("drop_busy_resp", 32'(bus.busy), 32'd1);
        step();
        check("drop_idle", 32'(bus.busy), 32'd0);

        // Flush together with a load grant also drops the result
        issue(1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd8);
        bus.dm_gnt = 1'b1;
        bus.flush  = 1'b1;
        step();
        bus.dm_gnt = 1'b0;
        bus.flush  = 1'b0;
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h7777_0000;
        step();
        bus.dm_rvalid = 1'b0;
        step();
        check("gntflush_idle", 32'(bus.busy), 32'd0);

        // A normal load afterwards still writes back (drop flag cleared)
        load_op(3'b010, 32'h0000_0608, 32'h0BAD_F00D, 5'd9, 32'h0BAD_F00D);

        // Reset while waiting: back to idle, late data ignored
        issue(1'b0, 3'b000, 32'h0000_0700, 32'h0, 5'd10);
        bus.dm_gnt = 1'b1;
        step();
        bus.dm_gnt = 1'b0;
        check("rstw_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw_ready", 32'(bus.req_ready), 32'd1);
        check("rstw_idle", 32'(bus.busy), 32'd0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h0000_00FF;
        step();
        bus.dm_rvalid = 1'b0;
        check("rstw_stray_idle", 32'(bus.busy), 32'd0);
        step();
        check("rstw_no_wb", 32'(bus.wb_valid), 32'd0);

        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
